// File: rtl/cdf_pipeline.sv
// cdf_pipeline: reads 256 histogram bins from m2, accumulates the running CDF,
// and writes {cdf, equalized level} for every bin into m3 at one bin per cycle.
module cdf_pipeline #(
   parameter int unsigned NUM_BINS = 256,
   parameter int unsigned PIX_LOG2 = 6,
   parameter logic [15:0] BIN_TAG  = 16'hAAAA
) (
   input  logic         clock,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] m2ReadVal,
   output logic [15:0]  m2ReadAddr,
   output logic [15:0]  m3WriteAddr,
   output logic [127:0] m3WriteVal,
   output logic         m3WE,
   output logic         done
);

   localparam int unsigned AW = 16;
   localparam int unsigned CW = 24;
   localparam int unsigned PW = 32;
   localparam int unsigned DW = 128;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BINS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     drain_cnt_q, drain_cnt_d;
   logic [AW-1:0]  rd_addr_q, rd_addr_d;
   logic           done_q, done_d;

   logic           m2_valid_q, m2_valid_d;
   logic [AW-1:0]  m2_addr_q, m2_addr_d;
   logic           f_valid_q, f_valid_d;
   logic [AW-1:0]  f_addr_q, f_addr_d;
   logic [15:0]    count_q, count_d;
   logic [CW-1:0]  cdf_q, cdf_d;
   logic           we_q, we_d;
   logic [AW-1:0]  wr_addr_q, wr_addr_d;
   logic [DW-1:0]  wr_val_q, wr_val_d;

   logic [CW-1:0]  cdf_sum;
   logic [PW-1:0]  prod;
   logic [PW-1:0]  lvl;
   logic [7:0]     mapped;

   // Upper read-data bits carry nothing for this stage.
   logic unused_hi;
   assign unused_hi = ^m2ReadVal[127:32];

   // Run sequencing: issue addresses, flush the pipeline, then report done.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      rd_addr_d   = rd_addr_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            rd_addr_d = '0;
            if (start) state_d = S_READ;
         end
         S_READ: begin
            if (rd_addr_q == LAST_ADDR) begin
               state_d     = S_DRAIN;
               drain_cnt_d = 2'd0;
            end else begin
               rd_addr_d = rd_addr_q + 16'd1;
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == 2'd2) state_d = S_DONE;
            else                     drain_cnt_d = drain_cnt_q + 2'd1;
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      // Dropping start aborts from anywhere.
      if (!start) begin
         state_d   = S_IDLE;
         rd_addr_d = '0;
      end
      done_d = (state_d == S_DONE);
   end

   // Fetch, tag-filter, accumulate and equalize; a write leaves every valid cycle.
   always_comb begin
      m2_valid_d = start && (state_q == S_READ);
      m2_addr_d  = rd_addr_q;
      f_valid_d  = start && m2_valid_q;
      f_addr_d   = m2_addr_q;
      count_d    = (m2ReadVal[31:16] == BIN_TAG) ? m2ReadVal[15:0] : 16'd0;

      cdf_sum = cdf_q + CW'(count_q);
      prod    = (PW'(cdf_sum) << 8) - PW'(cdf_sum);
      lvl     = prod >> PIX_LOG2;
      mapped  = (lvl > 32'd255) ? 8'hFF : lvl[7:0];

      we_d      = start && f_valid_q;
      cdf_d     = cdf_q;
      wr_addr_d = wr_addr_q;
      wr_val_d  = wr_val_q;
      if (!start || (state_q == S_IDLE)) cdf_d = '0;
      if (we_d) begin
         cdf_d     = cdf_sum;
         wr_addr_d = f_addr_q;
         wr_val_d  = {96'd0, cdf_sum, mapped};
      end
   end

   // All state and pipeline registers; async reset clears everything.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= '0;
         rd_addr_q   <= '0;
         done_q      <= 1'b0;
         m2_valid_q  <= 1'b0;
         m2_addr_q   <= '0;
         f_valid_q   <= 1'b0;
         f_addr_q    <= '0;
         count_q     <= '0;
         cdf_q       <= '0;
         we_q        <= 1'b0;
         wr_addr_q   <= '0;
         wr_val_q    <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         rd_addr_q   <= rd_addr_d;
         done_q      <= done_d;
         m2_valid_q  <= m2_valid_d;
         m2_addr_q   <= m2_addr_d;
         f_valid_q   <= f_valid_d;
         f_addr_q    <= f_addr_d;
         count_q     <= count_d;
         cdf_q       <= cdf_d;
         we_q        <= we_d;
         wr_addr_q   <= wr_addr_d;
         wr_val_q    <= wr_val_d;
      end
   end

   assign m2ReadAddr  = rd_addr_q;
   assign m3WriteAddr = wr_addr_q;
   assign m3WriteVal  = wr_val_q;
   assign m3WE        = we_q;
   assign done        = done_q;

endmodule
